// File: rtl/i2c_slave_core.sv
`timescale 1ns/1ps
// I2C target with a 16-bit register pointer (REGH, REGL) and strobe-based register read/write port.
// Optional feature: define I2C_SLAVE_AUTOINC_EN to advance reg_addr after each write and each ACKed read.
module i2c_slave_core #(
    parameter logic [6:0] DEV_ADDR = 7'h3C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic        reg_wr,
    output logic [7:0]  reg_wdata,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_DEV      = 4'd1;
    localparam logic [3:0] S_ACK_DEV  = 4'd2;
    localparam logic [3:0] S_REGH     = 4'd3;
    localparam logic [3:0] S_ACK_REGH = 4'd4;
    localparam logic [3:0] S_REGL     = 4'd5;
    localparam logic [3:0] S_ACK_REGL = 4'd6;
    localparam logic [3:0] S_WDATA    = 4'd7;
    localparam logic [3:0] S_ACK_W    = 4'd8;
    localparam logic [3:0] S_RDATA    = 4'd9;
    localparam logic [3:0] S_RACK     = 4'd10;

    logic        scl_s1_q, scl_s2_q, scl_prev_q;
    logic        sda_s1_q, sda_s2_q, sda_prev_q;
    logic [1:0]  arm_q, arm_d;
    logic [3:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [6:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic        ack_q, ack_d;
    logic        oe_q, oe_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        ld_q, ld_d;
    logic        busy_q, busy_d;

    logic armed, scl_rise, scl_fall, start_det, stop_det;

    // Edge detection stays blind until the synchronizer and history flops hold real pin levels.
    assign armed     = (arm_q == 2'd3);
    assign arm_d     = armed ? arm_q : arm_q + 2'd1;
    assign scl_rise  = armed &  scl_s2_q & ~scl_prev_q;
    assign scl_fall  = armed & ~scl_s2_q &  scl_prev_q;
    assign start_det = armed & scl_s2_q & scl_prev_q &  sda_prev_q & ~sda_s2_q;
    assign stop_det  = armed & scl_s2_q & scl_prev_q & ~sda_prev_q &  sda_s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        rw_d    = rw_q;
        ack_d   = ack_q;
        oe_d    = oe_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        rd_d    = 1'b0;
        ld_d    = rd_q;
        busy_d  = busy_q;

`ifdef I2C_SLAVE_AUTOINC_EN
        if (wr_q) begin
            addr_d = addr_q + 16'd1;
        end
`endif

        case (state_q)
            S_DEV, S_REGH, S_REGL, S_WDATA: begin
                if (scl_rise) begin
                    rx_d  = {rx_q[6:0], sda_s2_q};
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d = 4'd0;
                    if (state_q == S_DEV) begin
                        if (rx_q[7:1] == DEV_ADDR) begin
                            state_d = S_ACK_DEV;
                            oe_d    = 1'b1;
                            rw_d    = rx_q[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (state_q == S_REGH) begin
                        addr_d[15:8] = rx_q;
                        state_d      = S_ACK_REGH;
                        oe_d         = 1'b1;
                    end else if (state_q == S_REGL) begin
                        addr_d[7:0] = rx_q;
                        state_d     = S_ACK_REGL;
                        oe_d        = 1'b1;
                    end else begin
                        wr_d    = 1'b1;
                        wdata_d = rx_q;
                        state_d = S_ACK_W;
                        oe_d    = 1'b1;
                    end
                end
            end
            S_ACK_DEV, S_ACK_REGH, S_ACK_REGL, S_ACK_W: begin
                if (scl_fall) begin
                    oe_d  = 1'b0;
                    cnt_d = 4'd0;
                    case (state_q)
                        S_ACK_DEV: begin
                            if (rw_q) begin
                                state_d = S_RDATA;
                                rd_d    = 1'b1;
                            end else begin
                                state_d = S_REGH;
                            end
                        end
                        S_ACK_REGH: state_d = S_REGL;
                        default:    state_d = S_WDATA;
                    endcase
                end
            end
            S_RDATA: begin
                // Read data arrives one clk after reg_rd; the MSB goes out as soon as it is loaded.
                if (ld_q) begin
                    tx_d = reg_rdata[6:0];
                    oe_d = ~reg_rdata[7];
                end else if (scl_rise) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_RACK;
                    end else begin
                        oe_d = ~tx_q[6];
                        tx_d = {tx_q[5:0], 1'b1};
                    end
                end
            end
            S_RACK: begin
                if (scl_rise) begin
                    ack_d = ~sda_s2_q;
`ifdef I2C_SLAVE_AUTOINC_EN
                    if (!sda_s2_q) begin
                        addr_d = addr_q + 16'd1;
                    end
`endif
                end else if (scl_fall) begin
                    if (ack_q) begin
                        state_d = S_RDATA;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: ;
            default: state_d = S_IDLE;
        endcase

        // Bus conditions override whatever byte was in flight.
        if (start_det) begin
            state_d = S_DEV;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            ld_d    = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            ld_d    = 1'b0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
            arm_q      <= 2'd0;
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rx_q       <= 8'h00;
            tx_q       <= 7'h7F;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            addr_q     <= 16'h0000;
            wr_q       <= 1'b0;
            wdata_q    <= 8'h00;
            rd_q       <= 1'b0;
            ld_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            arm_q      <= arm_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            ld_q       <= ld_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe    = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wr    = wr_q;
    assign reg_wdata = wdata_q;
    assign reg_rd    = rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
`timescale 1ns/1ps
// Bench for i2c_slave_core: bit-banged I2C master, register-file environment and a transaction-level model.
module tb_i2c_slave_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        scl_in, sda_in, sda_oe, reg_wr, reg_rd, busy;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = 8'h00;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_slave_core #(.DEV_ADDR(7'h3C)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  dut_mem   [0:65535];
    logic [7:0]  model_mem [0:65535];
    logic [15:0] model_addr = 16'h0000;
    wr_t         exp_wr [$];
    wr_t         act_wr [0:1023];
    int          wr_n = 0;
    int          rd_n = 0;
    int          oe_n = 0;
    int          busy_n = 0;
    logic [15:0] last_rd_a = 16'h0000;

    // Register-file environment and activity monitor.
    always @(negedge clk) begin
        if (reg_wr) begin
            if (wr_n < 1024) begin
                act_wr[wr_n].a = reg_addr;
                act_wr[wr_n].d = reg_wdata;
            end
            wr_n++;
            dut_mem[reg_addr] = reg_wdata;
        end
        if (reg_rd) begin
            rd_n++;
            last_rd_a = reg_addr;
            reg_rdata = dut_mem[reg_addr];
        end
        if (sda_oe) oe_n++;
        if (busy) busy_n++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wq();
        repeat (5) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq(); wq();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        b = sda_in; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    // START, device byte, pointer high/low, nd data bytes, optional STOP.
    task automatic xfer_write(input logic [7:0] devb, input logic [15:0] ra, input int nd,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic do_stop, output int acks, output logic busy_pre);
        logic       a;
        logic [7:0] dd [3];
        dd = '{d0, d1, d2};
        acks = 0;
        i2c_start();
        write_byte(devb, a);     acks += int'(a);
        write_byte(ra[15:8], a); acks += int'(a);
        write_byte(ra[7:0], a);  acks += int'(a);
        for (int k = 0; k < nd; k++) begin
            write_byte(dd[k], a);
            acks += int'(a);
        end
        busy_pre = busy;
        if (do_stop) i2c_stop();
    endtask

    // Reference: pointer load, then each data byte lands at the pointer (which advances only with autoinc).
    task automatic model_apply(input logic [15:0] ra, input int nd,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] dd [3];
        dd = '{d0, d1, d2};
        model_addr = ra;
        for (int k = 0; k < nd; k++) begin
            exp_wr.push_back('{model_addr, dd[k]});
            model_mem[model_addr] = dd[k];
            if (AUTOINC) model_addr = model_addr + 16'd1;
        end
    endtask

    task automatic compare_writes(input string tag, input int w0);
        int n;
        n = wr_n - w0;
        check($sformatf("%s_nwr", tag), 32'(n), 32'(exp_wr.size()));
        for (int k = 0; k < n && k < exp_wr.size(); k++) begin
            check($sformatf("%s_wa%0d", tag, k), 32'(act_wr[w0 + k].a), 32'(exp_wr[k].a));
            check($sformatf("%s_wd%0d", tag, k), 32'(act_wr[w0 + k].d), 32'(exp_wr[k].d));
        end
        exp_wr.delete();
    endtask

    // With the block idle, a clocked byte with no START must not be acknowledged.
    task automatic idle_probe(input string tag);
        logic a;
        int   o0;
        o0 = oe_n;
        write_byte(8'h78, a);
        check($sformatf("%s_noack", tag), 32'(a), 32'd0);
        check($sformatf("%s_oe_quiet", tag), 32'(oe_n - o0), 32'd0);
        i2c_stop();
    endtask

    typedef struct {
        string       name;
        logic [7:0]  devb;
        logic [15:0] ra;
        int          nd;
        logic [7:0]  d0, d1;
        int          exp_acks;
        int          exp_nwr;
        logic [15:0] ea0, ea1;
        logic [7:0]  ed0, ed1;
    } vec_t;

    initial begin
        vec_t        vt [4];
        int          acks, w0, o0, b0, r0, nb, nd;
        logic        bp, a, mis;
        logic [7:0]  d, devb;
        logic [6:0]  dev7;
        logic [15:0] ra;
        logic [7:0]  dd [3];

        for (int i = 0; i < 65536; i++) begin
            dut_mem[i]   = 8'(i) ^ 8'(i >> 8) ^ 8'h3A;
            model_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3A;
        end

        vt[0] = '{"wr1234",  8'h78, 16'h1234, 1, 8'hA5, 8'h00, 4, 1, 16'h1234, 16'h0000, 8'hA5, 8'h00};
        vt[1] = '{"addr3D",  8'h7A, 16'h1234, 1, 8'h77, 8'h00, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00};
        vt[2] = '{"wrFFFF",  8'h78, 16'hFFFF, 2, 8'h01, 8'h02, 5, 2, 16'hFFFF,
                  (AUTOINC ? 16'h0000 : 16'hFFFF), 8'h01, 8'h02};
        vt[3] = '{"set0010", 8'h78, 16'h0010, 0, 8'h00, 8'h00, 3, 0, 16'h0000, 16'h0000, 8'h00, 8'h00};

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'h0000);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'h00);
        check("rst_reg_rd", 32'(reg_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Table-driven write transactions.
        for (int i = 0; i < 4; i++) begin
            w0 = wr_n; o0 = oe_n; b0 = busy_n; r0 = rd_n;
            xfer_write(vt[i].devb, vt[i].ra, vt[i].nd, vt[i].d0, vt[i].d1, 8'h00, 1'b1, acks, bp);
            check($sformatf("%s_acks", vt[i].name), 32'(acks), 32'(vt[i].exp_acks));
            check($sformatf("%s_nwr", vt[i].name), 32'(wr_n - w0), 32'(vt[i].exp_nwr));
            if (vt[i].exp_nwr > 0 && wr_n - w0 > 0) begin
                check($sformatf("%s_wa0", vt[i].name), 32'(act_wr[w0].a), 32'(vt[i].ea0));
                check($sformatf("%s_wd0", vt[i].name), 32'(act_wr[w0].d), 32'(vt[i].ed0));
            end
            if (vt[i].exp_nwr > 1 && wr_n - w0 > 1) begin
                check($sformatf("%s_wa1", vt[i].name), 32'(act_wr[w0 + 1].a), 32'(vt[i].ea1));
                check($sformatf("%s_wd1", vt[i].name), 32'(act_wr[w0 + 1].d), 32'(vt[i].ed1));
            end
            check($sformatf("%s_busy_pre_stop", vt[i].name), 32'(bp), 32'(vt[i].exp_acks > 0));
            check($sformatf("%s_busy_after_stop", vt[i].name), 32'(busy), 32'd0);
            check($sformatf("%s_oe_active", vt[i].name), 32'(oe_n > o0), 32'(vt[i].exp_acks > 0));
            check($sformatf("%s_busy_seen", vt[i].name), 32'(busy_n > b0), 32'(vt[i].exp_acks > 0));
            check($sformatf("%s_no_rd", vt[i].name), 32'(rd_n - r0), 32'd0);
            if (vt[i].exp_acks > 0) model_apply(vt[i].ra, vt[i].nd, vt[i].d0, vt[i].d1, 8'h00);
            exp_wr.delete();
            check($sformatf("%s_reg_addr", vt[i].name), 32'(reg_addr), 32'(model_addr));
        end

        // Read back from the retained pointer 0x0010 with master NAK.
        dut_mem[16'h0010] = 8'h5A; model_mem[16'h0010] = 8'h5A;
        r0 = rd_n;
        i2c_start();
        write_byte(8'h79, a);
        check("rd_dev_ack", 32'(a), 32'd1);
        read_byte(d, 1'b0);
        check("rd_busy_pre_stop", 32'(busy), 32'd1);
        i2c_stop();
        check("rd_data", 32'(d), 32'h5A);
        check("rd_pulses", 32'(rd_n - r0), 32'd1);
        check("rd_addr", 32'(last_rd_a), 32'h0010);
        check("rd_busy_after_stop", 32'(busy), 32'd0);

        // STOP after 4 bits of a data byte.
        w0 = wr_n;
        xfer_write(8'h78, 16'h2000, 0, 8'h00, 8'h00, 8'h00, 1'b0, acks, bp);
        check("abort_acks", 32'(acks), 32'd3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        check("abort_no_wr", 32'(wr_n - w0), 32'd0);
        check("abort_sda_oe", 32'(sda_oe), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        model_addr = 16'h2000;
        scl_m = 1'b0; wq();
        idle_probe("abort_idle");

        // One-clk reset while the target drives a read bit.
        dut_mem[16'h0020] = 8'h00; model_mem[16'h0020] = 8'h00;
        xfer_write(8'h78, 16'h0020, 0, 8'h00, 8'h00, 8'h00, 1'b1, acks, bp);
        check("rstmid_setup_acks", 32'(acks), 32'd3);
        i2c_start();
        write_byte(8'h79, a);
        check("rstmid_dev_ack", 32'(a), 32'd1);
        for (int i = 0; i < 30 && !sda_oe; i++) @(negedge clk);
        check("rstmid_oe_driven", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_sda_oe", 32'(sda_oe), 32'd0);
        check("rstmid_reg_addr", 32'(reg_addr), 32'h0000);
        check("rstmid_reg_wr", 32'(reg_wr), 32'd0);
        check("rstmid_reg_wdata", 32'(reg_wdata), 32'h00);
        check("rstmid_reg_rd", 32'(reg_rd), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        model_addr = 16'h0000;
        idle_probe("rstmid_idle");

        // Randomized transactions against the model.
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 2) < 2) begin
                mis = ($urandom_range(0, 4) == 0);
                dev7 = 7'h3C;
                if (mis) begin
                    do dev7 = 7'($urandom); while (dev7 == 7'h3C);
                end
                devb = {dev7, 1'b0};
                ra = 16'($urandom);
                nd = $urandom_range(0, 3);
                for (int k = 0; k < 3; k++) dd[k] = 8'($urandom);
                w0 = wr_n; o0 = oe_n;
                xfer_write(devb, ra, nd, dd[0], dd[1], dd[2], 1'b1, acks, bp);
                check($sformatf("rnd%0d_acks", t), 32'(acks), 32'(mis ? 0 : 3 + nd));
                if (!mis) model_apply(ra, nd, dd[0], dd[1], dd[2]);
                compare_writes($sformatf("rnd%0d", t), w0);
                check($sformatf("rnd%0d_busy", t), 32'(busy), 32'd0);
            end else begin
                w0 = wr_n;
                if ($urandom_range(0, 1) == 1) begin
                    ra = 16'($urandom);
                    xfer_write(8'h78, ra, 0, 8'h00, 8'h00, 8'h00, 1'($urandom_range(0, 1)), acks, bp);
                    check($sformatf("rnd%0d_setacks", t), 32'(acks), 32'd3);
                    model_addr = ra;
                end
                nb = $urandom_range(1, 3);
                r0 = rd_n;
                i2c_start();
                write_byte(8'h79, a);
                check($sformatf("rnd%0d_rdack", t), 32'(a), 32'd1);
                for (int k = 0; k < nb; k++) begin
                    read_byte(d, k < nb - 1);
                    check($sformatf("rnd%0d_rd%0d", t, k), 32'(d), 32'(model_mem[model_addr]));
                    if (AUTOINC && k < nb - 1) model_addr = model_addr + 16'd1;
                end
                i2c_stop();
                check($sformatf("rnd%0d_rdpulses", t), 32'(rd_n - r0), 32'(nb));
                compare_writes($sformatf("rnd%0d_rdwr", t), w0);
            end
            check($sformatf("rnd%0d_reg_addr", t), 32'(reg_addr), 32'(model_addr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_core.md
I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C, which is the 7-bit device address this target answers to.
REQ-002 SHALL have port clk, input, 1 bit: system clock, at least 10x the SCL rate.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port scl_in, input, 1 bit: raw SCL pin level (asynchronous).
REQ-005 SHALL have port sda_in, input, 1 bit: raw SDA pin level (asynchronous).
REQ-006 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain), 0 releases it.
REQ-007 SHALL have port reg_addr, output, 16 bits: current register address.
REQ-008 SHALL have port reg_wr, output, 1 bit: one-clk write strobe.
REQ-009 SHALL have port reg_wdata, output, 8 bits: write data, valid while reg_wr=1.
REQ-010 SHALL have port reg_rd, output, 1 bit: one-clk read strobe.
REQ-011 SHALL have port reg_rdata, input, 8 bits: read data, valid the clk after reg_rd.
REQ-012 SHALL have port busy, output, 1 bit: 1 from START to STOP while this target is addressed.

Function
REQ-013 SHALL pass scl_in and sda_in through a 2-flop synchronizer, then detect edges from the synchronized levels.
REQ-014 SHALL detect START/repeated START as SDA falling while SCL=1, and STOP as SDA rising while SCL=1; either SHALL be detected in any state.
REQ-015 SHALL sample SDA on SCL rising and change sda_oe only on SCL falling, after the synchronizer delay.
REQ-016 SHALL use states IDLE, DEV, ACK_DEV, REGH, ACK_REGH, REGL, ACK_REGL, WDATA, ACK_W, RDATA, RACK.
- START from any state goes to DEV; STOP from any state goes to IDLE.
REQ-017 DEV SHALL shift in 8 bits, MSB first.
- Address equals DEV_ADDR with R/W=0: go to ACK_DEV, then REGH.
- Address equals DEV_ADDR with R/W=1: go to ACK_DEV, then RDATA.
- Address mismatch: SDA stays released and the block goes to IDLE until the next START.
REQ-018 During each ACK state, sda_oe SHALL be 1 from the SCL falling edge after bit 8 until the next SCL falling edge.
REQ-019 REGH SHALL capture reg_addr[15:8] and REGL SHALL capture reg_addr[7:0]; each is followed by an ACK.
REQ-020 After ACK_REGL, each further 8-bit byte received SHALL produce one reg_wr pulse with reg_wdata set to that byte, at the SCL falling edge that starts ACK_W; ACK_W then returns to WDATA.
REQ-021 reg_addr SHALL be retained across STOP and repeated START, so that an address-only write followed by STOP/START plus a read returns data from that address.
REQ-022 On entry to RDATA, reg_rd SHALL pulse once, and reg_rdata SHALL be loaded into the TX shifter the next clk.
- Each bit is output as sda_oe = ~bit, MSB first.
- After 8 bits, sda_oe SHALL be released for RACK.
REQ-023 In RACK, the master bit SHALL be sampled on SCL rising.
- ACK (0): go to RDATA for the next byte.
- NAK (1): go to IDLE-wait with SDA released until STOP/START.
REQ-024 The block SHALL NOT stretch SCL and SHALL never drive SCL.
REQ-025 A START or STOP arriving mid-byte SHALL abort the byte: no reg_wr, sda_oe=0 within 1 clk, and the partial byte is discarded.

Reset
REQ-026 While rst_n=0 at a clk edge, outputs SHALL be: sda_oe=0, reg_addr=16'h0000, reg_wr=0, reg_wdata=8'h00, reg_rd=0, busy=0.
REQ-027 While rst_n=0, the state SHALL be IDLE, counters 0, and synchronizer flops 1.
REQ-028 After reset is released, the block SHALL ignore the bus until the first START, including when reset releases mid-transfer.

Configuration
REQ-029 With macro I2C_SLAVE_AUTOINC_EN defined, reg_addr SHALL increment by 1 (mod 2^16, 16'hFFFF wraps to 16'h0000) one clk after each reg_wr, and on each RACK=ACK before the next reg_rd.
REQ-030 Without I2C_SLAVE_AUTOINC_EN, reg_addr SHALL change only in REGH/REGL, and repeated data bytes SHALL all target the same address.

Verification
REQ-031 Bench SHALL cover: write 0x3C/W, 0x12, 0x34, 0xA5, STOP -> ACK on all 4 bytes; one reg_wr with reg_addr=0x1234 and reg_wdata=0xA5; busy falls at STOP.
REQ-032 Bench SHALL cover: write 0x3C/W, 0x00, 0x10, STOP; START 0x3C/R with reg_rdata=0x5A, master NAK -> reg_rd pulse at reg_addr=0x0010; SDA bits read back 0x5A.
REQ-033 Bench SHALL cover: address 0x3D/W -> sda_oe stays 0 for the whole transfer; no reg_wr/reg_rd; busy=0.
REQ-034 Bench SHALL cover: with AUTOINC_EN, write at 0xFFFF with data 0x01, 0x02 -> reg_wr at 0xFFFF then at 0x0000; without AUTOINC_EN -> both at 0xFFFF.
REQ-035 Bench SHALL cover: STOP injected after 4 bits of a data byte -> no reg_wr; state IDLE; sda_oe=0.
REQ-036 Bench SHALL cover: rst_n=0 for 1 clk during RDATA while sda_oe=1 -> sda_oe=0 the next clk; all outputs at reset values.
